shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Receive end of the multi-lane serial shifter interface: one bit per lane per enabled clock, assembled into a parallel frame of DEPTH bits per lane.
- Completed frames are presented on a held output register with a valid/acknowledge handshake to the downstream consumer.
- Sits directly after the lane shifter; its si/shn pair is this block's input.

Parameters:
- LANES, 4, number of serial lanes (width of si)
- DEPTH, 4, bits collected per lane per frame (>=2)
- CW, 3, bit-counter width; must satisfy 2^CW > DEPTH

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- si  input  LANES  serial data, bit L belongs to lane L
- shn  input  1  shift enable; si sampled on rising clk when 1
- clr  input  1  synchronous abort of the partial frame
- rd  input  1  consumer acknowledge of the current output frame
- po  output  LANES*DEPTH  assembled frame; lane L occupies po[L*DEPTH +: DEPTH]
- pv  output  1  po holds an unconsumed frame
- ovf  output  1  sticky; a completed frame was dropped
- cnt  output  CW  bits collected in the current partial frame

Behaviour:
- Reset (async, any time, including mid-frame): all lane shift registers 0, cnt=0, po=0, pv=0, ovf=0, FSM=IDLE. The partial frame is lost.
- FSM states:
  - IDLE: cnt=0. shn=1 moves to COLLECT.
  - COLLECT: 0<cnt<DEPTH.
  - FSM returns to IDLE when a frame completes or clr=1.
- Sampling: on each rising edge with shn=1 and clr=0, every lane register shifts left and takes si[L] into its LSB, and cnt increments. Bits are MSB-first: the first bit received ends up at lane bit DEPTH-1.
- shn=0 holds all registers and cnt. Gaps of any length are allowed mid-frame.
- Frame completion: on the edge where shn=1 and cnt==DEPTH-1, the frame is formed from the shifted registers plus the current si.
  - If accepted, that frame loads po on the same edge and pv=1.
  - cnt returns to 0 and the lane registers clear.
  - Latency: pv=1 and po valid immediately after the edge that samples the DEPTH-th bit.
- Handshake:
  - po and pv are held stable while pv=1 and rd=0.
  - A rising edge with pv=1 and rd=1 consumes the frame: pv goes to 0 and po holds its last value.
  - rd while pv=0 is ignored.
- Simultaneous completion and rd=1 with pv=1: the new frame loads po and pv stays 1. No bubble, no ovf.
- Overflow: completion while pv=1 and rd=0 drops the new frame. po is unchanged, ovf is set and stays set until rst. cnt still returns to 0.
- clr=1: cnt and lane registers go to 0 and FSM goes to IDLE. clr has priority over shn on that edge, and si is not sampled. po, pv and ovf are unaffected.
- cnt output equals the internal counter. It never reaches DEPTH and wraps to 0 at completion.

Test Plan:
- Reset then basic frame (LANES=4, DEPTH=4): rst=1 for 10 ns; then si=4'b1010, shn=1 for 4 clocks.
  - Required: pv=1 after 4th edge, po=16'hF0F0, cnt=0, ovf=0.
- Back-to-back with consume: after the above, hold rd=1 and drive si=4'b1100, shn=1 for 4 clocks.
  - Required: pv drops after first edge, returns to 1 after 4th, po=16'hFF00.
- Bit order and gaps: lane0 sequence 1,0,0,0 with other lanes 0, and shn=0 for 3 clocks between bits 2 and 3.
  - Required: cnt holds at 2 during the gap; final po=16'h0008.
- Overflow: complete frame A (si=4'b1111, giving po=16'hFFFF) with rd=0, then complete frame B (si=4'b0000) still with rd=0.
  - Required: po stays 16'hFFFF, ovf=1 persists until rst.
- Simultaneous complete and rd: with pv=1, assert rd=1 on the same edge as the 4th bit of si=4'b0110.
  - Required: pv stays 1, po=16'h0FF0.
- Abort and mid-frame reset:
  - clr=1 after 2 bits gives cnt=0; the next 4 bits form a clean frame.
  - Asserting rst asynchronously after 3 bits gives cnt=0, pv=0 and po=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/shift_deserializer.sv
// Purpose: multi-lane serial-to-parallel receiver; DEPTH bits per lane form one frame on po.
// Latency: pv/po are valid right after the edge that samples the DEPTH-th bit of a frame.
// Backpressure: po is held while pv=1 and rd=0; a frame completing then is dropped and ovf is set.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   si   - serial input, bit L belongs to lane L
//   shn  - shift enable, si sampled when 1
//   clr  - synchronous abort of the partial frame (wins over shn)
//   rd   - consumer acknowledge of the frame on po
//   po   - assembled frame, lane L at po[L*DEPTH +: DEPTH]
//   pv   - po holds an unconsumed frame
//   ovf  - sticky, a completed frame was dropped
//   cnt  - bits collected in the current partial frame
module shift_deserializer #(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       si,
    input  logic                   shn,
    input  logic                   clr,
    input  logic                   rd,
    output logic [LANES*DEPTH-1:0] po,
    output logic                   pv,
    output logic                   ovf,
    output logic [CW-1:0]          cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Only DEPTH-1 bits need to be stored per lane: the last bit of a frame
    // is taken straight from si on the completing edge.
    logic [LANES-1:0][DEPTH-2:0] sr;
    logic [LANES-1:0][DEPTH-1:0] shifted;

    logic sample;
    logic complete;
    logic accept;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            shifted[l] = {sr[l], si[l]};
        end
    end

    assign sample   = shn && !clr;
    assign complete = sample && (state == COLLECT) && (cnt == CW'(DEPTH - 1));
    // The output slot is free if empty or being consumed on this same edge.
    assign accept   = complete && (!pv || rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sample) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (clr || complete) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
            po  <= '0;
            pv  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (clr || complete) begin
                sr  <= '0;
                cnt <= '0;
            end else if (shn) begin
                for (int l = 0; l < LANES; l++) begin
                    sr[l] <= shifted[l][DEPTH-2:0];
                end
                cnt <= cnt + CW'(1);
            end

            if (accept) begin
                po <= shifted;
                pv <= 1'b1;
            end else if (complete) begin
                // Slot occupied and not acknowledged: drop the new frame.
                ovf <= 1'b1;
            end else if (pv && rd) begin
                pv <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (LANES=4, DEPTH=4, CW=3).
// Stimulus pushes each expected accepted frame into a queue; a monitor pops
// and compares whenever the DUT presents a new frame on po/pv.
module tb_shift_deserializer;

    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic                   clk;
    logic                   rst;
    logic [LANES-1:0]       si;
    logic                   shn;
    logic                   clr;
    logic                   rd;
    logic [LANES*DEPTH-1:0] po;
    logic                   pv;
    logic                   ovf;
    logic [CW-1:0]          cnt;

    int n_total;
    int n_pass;

    logic [LANES*DEPTH-1:0] exp_q[$];

    shift_deserializer #(
        .LANES(LANES),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .si (si),
        .shn(shn),
        .clr(clr),
        .rd (rd),
        .po (po),
        .pv (pv),
        .ovf(ovf),
        .cnt(cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [LANES-1:0] s);
        si  = s;
        shn = 1'b1;
        tick();
        shn = 1'b0;
    endtask

    // A new frame is presented when pv rises, or when pv stays high across an
    // edge at which rd was asserted (consume and reload on the same edge).
    logic prev_pv;
    logic prev_rd;
    initial begin
        prev_pv = 1'b0;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && pv && (!prev_pv || prev_rd)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL frame: unexpected frame 0x%0h, none expected", po);
                end else begin
                    chk("frame po", 32'(po), 32'(exp_q.pop_front()));
                end
            end
            prev_pv = pv;
            prev_rd = rd;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        si  = '0;
        shn = 1'b0;
        clr = 1'b0;
        rd  = 1'b0;
        #10;
        chk("reset po", 32'(po), 32'h0);
        chk("reset pv", 32'(pv), 32'h0);
        chk("reset ovf", 32'(ovf), 32'h0);
        chk("reset cnt", 32'(cnt), 32'h0);
        rst = 1'b0;
        tick();

        // Basic frame: lanes 1 and 3 all ones.
        exp_q.push_back(16'hF0F0);
        for (int i = 0; i < 3; i++) send(4'b1010);
        chk("basic cnt before last", 32'(cnt), 32'd3);
        send(4'b1010);
        chk("basic pv", 32'(pv), 32'h1);
        chk("basic cnt wrap", 32'(cnt), 32'h0);
        chk("basic ovf", 32'(ovf), 32'h0);

        // Back-to-back with rd held: first edge consumes, fourth loads.
        rd = 1'b1;
        exp_q.push_back(16'hFF00);
        send(4'b1100);
        chk("b2b pv drop", 32'(pv), 32'h0);
        for (int i = 0; i < 3; i++) send(4'b1100);
        chk("b2b pv return", 32'(pv), 32'h1);
        tick();
        rd = 1'b0;
        chk("consume pv", 32'(pv), 32'h0);

        // Bit order with a gap between bits 2 and 3.
        exp_q.push_back(16'h0008);
        send(4'b0001);
        send(4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap cnt hold", 32'(cnt), 32'd2);
        end
        send(4'b0000);
        send(4'b0000);
        chk("gap frame pv", 32'(pv), 32'h1);

        rd = 1'b1;
        tick();
        rd = 1'b0;

        // Overflow: A accepted, B dropped.
        exp_q.push_back(16'hFFFF);
        for (int i = 0; i < 4; i++) send(4'b1111);
        chk("ovf before drop", 32'(ovf), 32'h0);
        for (int i = 0; i < 4; i++) send(4'b0000);
        chk("ovf set", 32'(ovf), 32'h1);
        chk("ovf po held", 32'(po), 32'hFFFF);
        chk("ovf pv held", 32'(pv), 32'h1);
        chk("ovf cnt wrap", 32'(cnt), 32'h0);

        // Completion and rd on the same edge.
        exp_q.push_back(16'h0FF0);
        for (int i = 0; i < 3; i++) send(4'b0110);
        rd = 1'b1;
        send(4'b0110);
        rd = 1'b0;
        chk("simul pv", 32'(pv), 32'h1);
        chk("simul po", 32'(po), 32'h0FF0);
        chk("ovf sticky", 32'(ovf), 32'h1);

        rd = 1'b1;
        tick();
        rd = 1'b0;

        // Abort after two bits; clr beats shn and si is ignored.
        send(4'b1111);
        send(4'b1111);
        chk("clr cnt before", 32'(cnt), 32'd2);
        clr = 1'b1;
        send(4'b1111);
        clr = 1'b0;
        chk("clr cnt", 32'(cnt), 32'h0);
        chk("clr pv", 32'(pv), 32'h0);
        exp_q.push_back(16'h000F);
        for (int i = 0; i < 4; i++) send(4'b0001);
        chk("clean frame po", 32'(po), 32'h000F);

        // Asynchronous reset mid-frame, pv=1 and ovf=1 beforehand.
        for (int i = 0; i < 3; i++) send(4'b0001);
        chk("pre-rst cnt", 32'(cnt), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst cnt", 32'(cnt), 32'h0);
        chk("async rst pv", 32'(pv), 32'h0);
        chk("async rst po", 32'(po), 32'h0);
        chk("async rst ovf", 32'(ovf), 32'h0);
        #1;
        rst = 1'b0;
        tick();

        // Recovery after reset.
        exp_q.push_back(16'hF0F0);
        for (int i = 0; i < 4; i++) send(4'b1010);
        chk("recover pv", 32'(pv), 32'h1);
        chk("recover ovf", 32'(ovf), 32'h0);

        tick();
        tick();
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
